score_display: RTL

//  Downstream of the score logic in the Genius game: captures the 8-bit POINTS value on a strobe,

---
 rtl/genius_pkg.sv | 45 ++++
 rtl/score_display_if.sv | 26 ++
 rtl/bin2bcd_serial.sv | 50 +++++
 rtl/score_display.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius score display slice: the
// display FSM states, the active-low 7-segment patterns ({g..a}) and the
// score width.
package genius_pkg;

   localparam int W_PTS   = 8;
   localparam int N_SHIFT = W_PTS;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE
   } state_t;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // A BCD nibble above 9 cannot come out of the converter; blank it if it ever does.
   function automatic logic [6:0] segEncode(input logic [3:0] digit);
      case (digit)
         4'd0:    segEncode = SEG_0;
         4'd1:    segEncode = SEG_1;
         4'd2:    segEncode = SEG_2;
         4'd3:    segEncode = SEG_3;
         4'd4:    segEncode = SEG_4;
         4'd5:    segEncode = SEG_5;
         4'd6:    segEncode = SEG_6;
         4'd7:    segEncode = SEG_7;
         4'd8:    segEncode = SEG_8;
         4'd9:    segEncode = SEG_9;
         default: segEncode = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/score_display_if.sv
// Strobe-in / digits-out bundle between the score logic (master) and the
// score display (slave).
interface score_display_if #(
   parameter int W_PTS = 8
);
   logic             SHOW;
   logic [W_PTS-1:0] POINTS;
   logic [1:0]       REG_SetupLEVEL;
   logic             SEL_HI;
   logic [6:0]       HEX0;
   logic [6:0]       HEX1;
   logic [6:0]       HEX2;
   logic             BUSY;
   logic             DONE;
   logic             NEW_RECORD;

   modport master (
      output SHOW, POINTS, REG_SetupLEVEL, SEL_HI,
      input  HEX0, HEX1, HEX2, BUSY, DONE, NEW_RECORD
   );

   modport slave (
      input  SHOW, POINTS, REG_SetupLEVEL, SEL_HI,
      output HEX0, HEX1, HEX2, BUSY, DONE, NEW_RECORD
   );
endinterface

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: start loads the binary value and clears
// the BCD register, then each shift cycle adds 3 to every BCD nibble >= 5
// and shifts {bcd,bin} left by one. done flags the last of N_SHIFT shifts.
module bin2bcd_serial
   import genius_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             shift_i,
   input  logic [W_PTS-1:0] bin_i,
   output logic [11:0]      bcd_o,
   output logic             done_o
);

   logic [W_PTS-1:0] bin_q;
   logic [11:0]      bcd_q;
   logic [2:0]       cnt_q;
   logic [11:0]      bcdAdj;

   // Add-3 correction applied to each nibble ahead of the shift.
   always_comb begin
      bcdAdj = bcd_q;
      for (int i = 0; i < 3; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcdAdj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Load on start, otherwise shift the combined register once per shift cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q <= '0;
         bcd_q <= '0;
         cnt_q <= '0;
      end else if (start_i) begin
         bin_q <= bin_i;
         bcd_q <= '0;
         cnt_q <= '0;
      end else if (shift_i) begin
         {bcd_q, bin_q} <= {bcdAdj[10:0], bin_q, 1'b0};
         cnt_q          <= cnt_q + 3'd1;
      end
   end

   assign bcd_o  = bcd_q;
   assign done_o = shift_i && (cnt_q == 3'(N_SHIFT - 1));

endmodule

// File: rtl/score_display.sv
// Genius score display: captures POINTS on SHOW, converts it to three BCD
// digits serially and drives three active-low 7-segment digits.
// Define SCORE_HISCORE_EN to add the per-level high-score table, the SEL_HI
// source select and the NEW_RECORD flag.
module score_display
   import genius_pkg::*;
(
   input  logic           CLK,
   input  logic           RST_N,
   score_display_if.slave bus
);

   state_t           state_q, state_d;
   logic [W_PTS-1:0] pts_q;
   logic [W_PTS-1:0] srcVal;
   logic             convStart, convShift, convDone;
   logic [11:0]      bcdVal;
   logic [6:0]       hex0_q, hex1_q, hex2_q;
   logic             done_q;
   logic             showAccept;

   assign showAccept = (state_q == IDLE) && bus.SHOW;

   // State register; reset aborts any conversion in flight.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and converter control.
   always_comb begin
      state_d   = state_q;
      convStart = 1'b0;
      convShift = 1'b0;
      case (state_q)
         IDLE:  if (bus.SHOW) state_d = LOAD;
         LOAD:  begin
            convStart = 1'b1;
            state_d   = SHIFT;
         end
         SHIFT: begin
            convShift = 1'b1;
            if (convDone) state_d = DONE;
         end
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Latch the score at the accepted strobe so later POINTS changes do not matter.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pts_q <= '0;
      end else if (showAccept) begin
         pts_q <= bus.POINTS;
      end
   end

`ifdef SCORE_HISCORE_EN
   logic [1:0]       lvl_q;
   logic             sel_q;
   logic [W_PTS-1:0] hiTable_q [4];
   logic             recPend_q;
   logic             newRec_q;

   // Latch level and source select alongside the score.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         lvl_q <= '0;
         sel_q <= 1'b0;
      end else if (showAccept) begin
         lvl_q <= bus.REG_SetupLEVEL;
         sel_q <= bus.SEL_HI;
      end
   end

   assign srcVal = sel_q ? hiTable_q[lvl_q] : pts_q;

   // Table update at LOAD: only a strictly higher live score is a record.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < 4; i++) hiTable_q[i] <= '0;
         recPend_q <= 1'b0;
      end else if (state_q == LOAD) begin
         if (!sel_q && (pts_q > hiTable_q[lvl_q])) begin
            hiTable_q[lvl_q] <= pts_q;
            recPend_q        <= 1'b1;
         end else begin
            recPend_q <= 1'b0;
         end
      end
   end

   // Record flag: cleared by an accepted strobe, published with the new digits.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         newRec_q <= 1'b0;
      end else if (showAccept) begin
         newRec_q <= 1'b0;
      end else if (state_q == DONE) begin
         newRec_q <= recPend_q;
      end
   end

   assign bus.NEW_RECORD = newRec_q;
`else
   logic unusedCfg;
   assign unusedCfg      = ^{bus.REG_SetupLEVEL, bus.SEL_HI};
   assign srcVal         = pts_q;
   assign bus.NEW_RECORD = 1'b0;
`endif

   bin2bcd_serial u_conv (
      .clk     (CLK),
      .rst_n   (RST_N),
      .start_i (convStart),
      .shift_i (convShift),
      .bin_i   (srcVal),
      .bcd_o   (bcdVal),
      .done_o  (convDone)
   );

   // Digits change only on the DONE exit edge, so partial results never show.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         hex0_q <= SEG_0;
         hex1_q <= SEG_0;
         hex2_q <= SEG_0;
         done_q <= 1'b0;
      end else begin
         done_q <= (state_q == DONE);
         if (state_q == DONE) begin
            hex0_q <= segEncode(bcdVal[3:0]);
            hex1_q <= segEncode(bcdVal[7:4]);
            hex2_q <= segEncode(bcdVal[11:8]);
         end
      end
   end

   assign bus.HEX0 = hex0_q;
   assign bus.HEX1 = hex1_q;
   assign bus.HEX2 = hex2_q;
   assign bus.DONE = done_q;
   assign bus.BUSY = (state_q != IDLE);

endmodule
